// File: rtl/chirp_capture_sequencer.sv
// chirp_capture_sequencer
// Pulse-train sequencer for the chirp DDS / ADC capture path (clk_245 domain).
// Issues chirp_init/chirp_enable to the DDS, gates adc_enable for capture and
// repeats chirps every prf_period cycles. Finite (pulse_count > 0) and
// continuous (pulse_count == 0) trains, PRI overrun detection, abort.
//
// Ports
//   clk_245, clk_245_rst         : clock, synchronous active-high reset
//   seq_start, seq_abort         : start (IDLE only) / abort (any state)
//   prf_period, pulse_count,
//   adc_pre_delay, adc_capture_len : configuration, latched on seq_start
//   chirp_ready, chirp_done      : DDS handshake
//   chirp_active                 : DDS status, not used for sequencing
//   chirp_init, chirp_enable     : DDS control
//   adc_enable                   : capture window
//   seq_busy, seq_done, seq_error, pulse_index : sequence status
//
// state | meaning
// IDLE  | waiting for seq_start
// ARM   | waiting for chirp_ready before launching the next chirp
// RUN   | chirp in flight, PRI counter p running from 0 at chirp_init
// DONE  | one-cycle seq_done, then back to IDLE
module chirp_capture_sequencer #(
    parameter int PRI_WIDTH = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk_245,
    input  logic                 clk_245_rst,
    input  logic                 seq_start,
    input  logic                 seq_abort,
    input  logic [PRI_WIDTH-1:0] prf_period,
    input  logic [CNT_WIDTH-1:0] pulse_count,
    input  logic [CNT_WIDTH-1:0] adc_pre_delay,
    input  logic [PRI_WIDTH-1:0] adc_capture_len,
    input  logic                 chirp_ready,
    input  logic                 chirp_done,
    input  logic                 chirp_active,
    output logic                 chirp_init,
    output logic                 chirp_enable,
    output logic                 adc_enable,
    output logic                 seq_busy,
    output logic                 seq_done,
    output logic                 seq_error,
    output logic [CNT_WIDTH-1:0] pulse_index
);

    // p is one bit wider than the PRI so it can saturate on a long last pulse
    localparam int P_W   = PRI_WIDTH + 1;
    localparam int WIN_W = PRI_WIDTH + 2;
    localparam logic [PRI_WIDTH-1:0] PRI_ONE = 1;
    localparam logic [P_W-1:0]       P_ONE   = 1;
    localparam logic [CNT_WIDTH-1:0] IDX_ONE = 1;

    typedef enum logic [1:0] {IDLE, ARM, RUN, DONE} state_t;

    state_t               state, state_nx;
    logic [PRI_WIDTH-1:0] prf_lat, prf_nx;
    logic [CNT_WIDTH-1:0] count_lat, count_nx;
    logic [CNT_WIDTH-1:0] pre_lat, pre_nx;
    logic [PRI_WIDTH-1:0] len_lat, len_nx;
    logic [P_W-1:0]       p, p_nx;
    logic                 done_seen, done_seen_nx;
    logic                 chirp_init_nx, chirp_enable_nx, adc_enable_nx;
    logic                 seq_busy_nx, seq_done_nx, seq_error_nx;
    logic [CNT_WIDTH-1:0] pulse_index_nx;
    logic                 launch;

    logic                 unused_status;
    assign unused_status = chirp_active;

    logic [WIN_W-1:0] pre_ext, win_end;
    logic [P_W-1:0]   p_inc;
    logic             cap_ended, complete, last_pulse, pri_end;

    assign pre_ext    = {{(WIN_W-CNT_WIDTH){1'b0}}, pre_lat};
    assign win_end    = pre_ext + {2'b00, len_lat};
    assign p_inc      = (&p) ? p : p + P_ONE;
    // a zero-length window counts as already ended
    assign cap_ended  = (len_lat == '0) || ({1'b0, p} >= win_end);
    assign complete   = (done_seen || chirp_done) && cap_ended;
    assign last_pulse = (count_lat != '0) && (pulse_index == count_lat);
    assign pri_end    = (p == {1'b0, prf_lat - PRI_ONE});

    always_ff @(posedge clk_245) begin
        if (clk_245_rst) begin
            state        <= IDLE;
            prf_lat      <= '0;
            count_lat    <= '0;
            pre_lat      <= '0;
            len_lat      <= '0;
            p            <= '0;
            done_seen    <= 1'b0;
            chirp_init   <= 1'b0;
            chirp_enable <= 1'b0;
            adc_enable   <= 1'b0;
            seq_busy     <= 1'b0;
            seq_done     <= 1'b0;
            seq_error    <= 1'b0;
            pulse_index  <= '0;
        end else begin
            state        <= state_nx;
            prf_lat      <= prf_nx;
            count_lat    <= count_nx;
            pre_lat      <= pre_nx;
            len_lat      <= len_nx;
            p            <= p_nx;
            done_seen    <= done_seen_nx;
            chirp_init   <= chirp_init_nx;
            chirp_enable <= chirp_enable_nx;
            adc_enable   <= adc_enable_nx;
            seq_busy     <= seq_busy_nx;
            seq_done     <= seq_done_nx;
            seq_error    <= seq_error_nx;
            pulse_index  <= pulse_index_nx;
        end
    end

    always_comb begin
        state_nx        = state;
        prf_nx          = prf_lat;
        count_nx        = count_lat;
        pre_nx          = pre_lat;
        len_nx          = len_lat;
        p_nx            = p;
        done_seen_nx    = done_seen;
        chirp_enable_nx = chirp_enable;
        seq_error_nx    = seq_error;
        pulse_index_nx  = pulse_index;
        launch          = 1'b0;

        if (seq_abort) begin
            state_nx        = IDLE;
            chirp_enable_nx = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (seq_start) begin
                        prf_nx         = prf_period;
                        count_nx       = pulse_count;
                        pre_nx         = adc_pre_delay;
                        len_nx         = adc_capture_len;
                        pulse_index_nx = '0;
                        seq_error_nx   = (prf_period == '0);
                        state_nx       = (prf_period == '0) ? DONE : ARM;
                    end
                end
                ARM: begin
                    if (chirp_ready) launch = 1'b1;
                end
                RUN: begin
                    p_nx = p_inc;
                    if (chirp_done) begin
                        done_seen_nx    = 1'b1;
                        chirp_enable_nx = 1'b0;
                    end
                    // the last pulse of a finite train is not bound by the PRI
                    if (last_pulse) begin
                        if (complete) state_nx = DONE;
                    end else if (pri_end) begin
                        if (!complete) begin
                            state_nx        = IDLE;
                            chirp_enable_nx = 1'b0;
                            seq_error_nx    = 1'b1;
                        end else if (chirp_ready) begin
                            // relaunch directly so chirp spacing is exactly the PRI
                            launch = 1'b1;
                        end else begin
                            state_nx = ARM;
                        end
                    end
                end
                DONE: state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end

        if (launch) begin
            state_nx        = RUN;
            p_nx            = '0;
            done_seen_nx    = 1'b0;
            chirp_enable_nx = 1'b1;
            pulse_index_nx  = pulse_index + IDX_ONE;
        end

        chirp_init_nx = launch;
        adc_enable_nx = (state_nx == RUN) && ({1'b0, p_nx} >= pre_ext)
                        && ({1'b0, p_nx} < win_end);
        seq_busy_nx   = (state_nx != IDLE);
        seq_done_nx   = (state_nx == DONE);
    end

endmodule

// File: tb/tb_chirp_capture_sequencer.sv
// tb_chirp_capture_sequencer
// Self-checking bench for chirp_capture_sequencer. A pulse-level reference
// model computes the expected per-cycle outputs of each sequence (chirp launch
// times, enable/capture windows, done/error/busy) from the configuration and
// the chirp_ready pattern; the DUT outputs are compared every cycle. Directed
// sequences cover the documented scenarios, then randomized ones follow.
module tb_chirp_capture_sequencer;

    localparam int HZ = 1024;

    logic        clk_245 = 1'b0;
    logic        clk_245_rst;
    logic        seq_start, seq_abort;
    logic [31:0] prf_period;
    logic [15:0] pulse_count, adc_pre_delay;
    logic [31:0] adc_capture_len;
    logic        chirp_ready, chirp_done, chirp_active;
    logic        chirp_init, chirp_enable, adc_enable;
    logic        seq_busy, seq_done, seq_error;
    logic [15:0] pulse_index;

    always #2 clk_245 = ~clk_245;

    chirp_capture_sequencer dut (
        .clk_245         (clk_245),
        .clk_245_rst     (clk_245_rst),
        .seq_start       (seq_start),
        .seq_abort       (seq_abort),
        .prf_period      (prf_period),
        .pulse_count     (pulse_count),
        .adc_pre_delay   (adc_pre_delay),
        .adc_capture_len (adc_capture_len),
        .chirp_ready     (chirp_ready),
        .chirp_done      (chirp_done),
        .chirp_active    (chirp_active),
        .chirp_init      (chirp_init),
        .chirp_enable    (chirp_enable),
        .adc_enable      (adc_enable),
        .seq_busy        (seq_busy),
        .seq_done        (seq_done),
        .seq_error       (seq_error),
        .pulse_index     (pulse_index)
    );

    int n_chk = 0;
    int n_fail = 0;

    bit          rdy    [HZ];
    bit          e_init [HZ];
    bit          e_cen  [HZ];
    bit          e_adc  [HZ];
    bit          e_busy [HZ];
    bit          e_done [HZ];
    bit          e_err  [HZ];
    logic [15:0] e_idx  [HZ];

    int init_k [8];
    int n_init;
    int done_k;

    int r_prf, r_pc, r_pre, r_len, r_dl, r_sa, r_sl, r_ab;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_245);
        #1;
    endtask

    // Offsets are cycles after the seq_start cycle (offset 0).
    task automatic model(input int prf, input int pc, input int pre, input int len,
                         input int dl, input int abort_at, input int rst_at,
                         output int end_k);
        int  t0, c, n, e, cap_end;
        bit  fin;
        for (int k = 0; k < HZ; k++) begin
            e_init[k] = 0; e_cen[k] = 0; e_adc[k] = 0; e_busy[k] = 0;
            e_done[k] = 0; e_err[k] = 0; e_idx[k] = '0;
        end
        end_k = 2;
        if (prf == 0) begin
            e_done[1] = 1;
            for (int k = 1; k < HZ; k++) e_err[k] = 1;
        end else begin
            n = 0;
            fin = 0;
            c = 1;
            while (c < HZ - 1 && !rdy[c]) c++;
            t0 = c + 1;
            while (!fin) begin
                if (t0 >= HZ - 4) begin
                    end_k = HZ - 4;
                    fin = 1;
                end else begin
                    n++;
                    e_init[t0] = 1;
                    for (int k = t0; k < HZ; k++) e_idx[k] = 16'(n);
                    for (int k = t0; k <= t0 + dl && k < HZ; k++) e_cen[k] = 1;
                    for (int k = t0 + pre; k < t0 + pre + len && k < HZ; k++) e_adc[k] = 1;
                    cap_end = (len == 0) ? t0 : t0 + pre + len;
                    e = (t0 + dl > cap_end) ? t0 + dl : cap_end;
                    if (pc != 0 && n == pc) begin
                        if (e + 1 < HZ) e_done[e + 1] = 1;
                        end_k = e + 2;
                        fin = 1;
                    end else if (e <= t0 + prf - 1) begin
                        c = t0 + prf - 1;
                        while (c < HZ - 1 && !rdy[c]) c++;
                        t0 = c + 1;
                    end else begin
                        for (int k = t0 + prf; k < HZ; k++) begin
                            e_cen[k] = 0; e_adc[k] = 0; e_err[k] = 1;
                        end
                        end_k = t0 + prf;
                        fin = 1;
                    end
                end
            end
        end
        if (end_k > HZ - 4) end_k = HZ - 4;
        for (int k = 1; k < end_k; k++) e_busy[k] = 1;
        if (abort_at >= 1 && abort_at < end_k) begin
            for (int k = abort_at + 1; k < HZ; k++) begin
                e_init[k] = 0; e_cen[k] = 0; e_adc[k] = 0; e_busy[k] = 0; e_done[k] = 0;
                e_err[k] = e_err[abort_at];
                e_idx[k] = e_idx[abort_at];
            end
            end_k = abort_at + 1;
        end
        if (rst_at >= 1 && rst_at < end_k) begin
            for (int k = rst_at + 1; k < HZ; k++) begin
                e_init[k] = 0; e_cen[k] = 0; e_adc[k] = 0; e_busy[k] = 0; e_done[k] = 0;
                e_err[k] = 0; e_idx[k] = '0;
            end
            end_k = rst_at + 1;
        end
    endtask

    task automatic run_seq(input string name, input int prf, input int pc, input int pre,
                           input int len, input int dl, input int st_at, input int st_len,
                           input int abort_at, input int rst_at);
        int end_k, done_due;
        for (int k = 0; k < HZ; k++) rdy[k] = !(k >= st_at && k < st_at + st_len);
        model(prf, pc, pre, len, dl, abort_at, rst_at, end_k);
        n_init = 0;
        done_k = -1;
        done_due = -1;
        prf_period      = prf;
        pulse_count     = 16'(pc);
        adc_pre_delay   = 16'(pre);
        adc_capture_len = len;
        seq_start       = 1'b1;
        seq_abort       = 1'b0;
        chirp_ready     = rdy[0];
        chirp_done      = 1'b0;
        clk_245_rst     = 1'b0;
        for (int k = 1; k <= end_k + 3; k++) begin
            step();
            chk_eq($sformatf("%s_cyc%0d", name, k),
                   {10'd0, chirp_init, chirp_enable, adc_enable, seq_busy, seq_done,
                    seq_error, pulse_index},
                   {10'd0, e_init[k], e_cen[k], e_adc[k], e_busy[k], e_done[k],
                    e_err[k], e_idx[k]});
            if (chirp_init) begin
                if (n_init < 8) init_k[n_init] = k;
                n_init++;
                done_due = k + dl;
            end
            if (seq_done && done_k < 0) done_k = k;
            chirp_ready     = rdy[k];
            chirp_done      = (k == done_due);
            seq_abort       = (k == abort_at);
            clk_245_rst     = (k == rst_at);
            // starts while busy (and alongside an abort) must be ignored
            seq_start       = e_busy[k] && (k == abort_at || $urandom_range(0, 7) == 0);
            prf_period      = $urandom;
            pulse_count     = 16'($urandom);
            adc_pre_delay   = 16'($urandom);
            adc_capture_len = $urandom;
        end
    endtask

    initial begin
        clk_245_rst     = 1'b1;
        seq_start       = 1'b0;
        seq_abort       = 1'b0;
        prf_period      = '0;
        pulse_count     = '0;
        adc_pre_delay   = '0;
        adc_capture_len = '0;
        chirp_ready     = 1'b1;
        chirp_done      = 1'b0;
        chirp_active    = 1'b0;
        repeat (3) step();
        chk_eq("rst_state",
               {25'd0, chirp_init, chirp_enable, adc_enable, seq_busy, seq_done, seq_error, 1'b0},
               32'd0);
        chk_eq("rst_index", {16'd0, pulse_index}, 32'd0);
        clk_245_rst = 1'b0;
        step();

        run_seq("finite", 100, 3, 4, 50, 60, 0, 0, -1, -1);
        chk_eq("fin_inits", n_init, 3);
        chk_eq("fin_init0", init_k[0], 2);
        chk_eq("fin_init1", init_k[1], 102);
        chk_eq("fin_init2", init_k[2], 202);
        chk_eq("fin_done", done_k, 263);

        run_seq("stall", 100, 3, 4, 50, 60, 101, 20, -1, -1);
        chk_eq("stall_init1", init_k[1], 122);

        run_seq("overrun", 40, 2, 4, 50, 60, 0, 0, -1, -1);
        chk_eq("ovr_inits", n_init, 1);
        chk_eq("ovr_no_done", done_k, -1);

        run_seq("abort", 100, 0, 4, 50, 60, 0, 0, 22, -1);
        chk_eq("abort_no_done", done_k, -1);

        run_seq("after_abort", 100, 2, 4, 50, 60, 0, 0, -1, -1);

        run_seq("zero_prf", 0, 3, 4, 50, 60, 0, 0, -1, -1);
        chk_eq("zero_done", done_k, 1);
        chk_eq("zero_inits", n_init, 0);

        run_seq("rst_mid", 100, 3, 4, 50, 60, 0, 0, -1, 30);
        run_seq("after_rst", 100, 3, 4, 50, 60, 0, 0, -1, -1);
        chk_eq("after_rst_done", done_k, 263);

        for (int i = 0; i < 12; i++) begin
            r_prf = ($urandom_range(0, 4) == 0) ? int'($urandom_range(2, 8))
                                                 : int'($urandom_range(20, 120));
            r_pc  = $urandom_range(0, 4);
            r_pre = $urandom_range(0, 10);
            r_len = $urandom_range(0, 60);
            r_dl  = $urandom_range(1, r_prf + 10);
            r_sa  = $urandom_range(1, 300);
            r_sl  = $urandom_range(0, 30);
            r_ab  = (r_pc == 0 || $urandom_range(0, 3) == 0) ? int'($urandom_range(5, 400)) : -1;
            run_seq($sformatf("rand%0d", i), r_prf, r_pc, r_pre, r_len, r_dl,
                    r_sa, r_sl, r_ab, -1);
        end

        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
